// File: rtl/zymason_scan_mux.sv
// ---------------------------------------------------------------------------
// zymason_scan_mux
//
// Time-multiplexed seven-segment display scanner. Each digit gets a slot made
// of an all-off BLANK phase (anti-ghosting) followed by a SHOW phase of
// 2^DWELL_W cycles. Inside SHOW the segments are PWM-dimmed using the top
// three bits of the dwell counter against the brightness level, and digits
// flagged in blink_mask go dark for half of every 64-frame period.
//
// Parameters
//   NUM_DIGITS  number of multiplexed digits
//   DWELL_W     SHOW phase length is 2^DWELL_W cycles (must be >= 3)
//   BLANK_CYC   all-off cycles before each digit (must be >= 1)
//
// Ports
//   clock       single clock, rising edge
//   reset       synchronous, active-high; overrides en
//   en          scan enable; dropping it returns to IDLE on the next edge
//   digits      packed segment patterns, digit i at [7i+6:7i], bit 0 = seg a
//   bright      brightness 0..7 (7 = always lit, 0 = 1/8 duty)
//   blink_mask  1 = that digit blinks
//   seg         registered segment drive, active-high
//   an          registered digit select, one-hot or all-zero
//   frame_done  one-cycle pulse at the start of each frame after the first
// ---------------------------------------------------------------------------
module zymason_scan_mux #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DWELL_W    = 8,
  parameter int unsigned BLANK_CYC  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic [7*NUM_DIGITS-1:0] digits,
  input  logic [2:0]              bright,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BLANK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLANK_W-1:0] LAST_BLANK = BLANK_W'(BLANK_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     index_q, index_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [BLANK_W-1:0]   blank_q, blank_d;
  logic [5:0]           frame_q, frame_d;
  logic [6:0]           shadow_q, shadow_d;
  logic                 frame_done_d;

  logic [6:0]           slot_digit;
  logic [NUM_DIGITS-1:0] an_onehot;
  logic                 blink_sel;
  logic                 dark;
  logic                 lit;
  logic [6:0]           seg_d;
  logic [NUM_DIGITS-1:0] an_d;

  // Pattern of the digit whose slot is currently running; captured into the
  // shadow register when BLANK hands over to SHOW.
  always_comb begin
    slot_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (index_q == IDX_W'(i)) begin
        slot_digit = digits[7*i +: 7];
      end
    end
  end

  // Next-state logic. en low collapses everything back to IDLE but leaves the
  // frame counter alone so the blink phase survives a pause.
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    dwell_d      = dwell_q;
    blank_d      = blank_q;
    frame_d      = frame_q;
    shadow_d     = shadow_q;
    frame_done_d = 1'b0;

    if (!en) begin
      state_d = IDLE;
      index_d = '0;
      dwell_d = '0;
      blank_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BLANK;
          index_d = '0;
          dwell_d = '0;
          blank_d = '0;
        end
        BLANK: begin
          if (blank_q == LAST_BLANK) begin
            state_d  = SHOW;
            dwell_d  = '0;
            shadow_d = slot_digit;
          end else begin
            blank_d = blank_q + BLANK_W'(1);
          end
        end
        SHOW: begin
          if (&dwell_q) begin
            state_d = BLANK;
            blank_d = '0;
            dwell_d = '0;
            if (index_q == LAST_IDX) begin
              // Wrap to digit 0 closes a frame; the pulse lands on the first
              // BLANK cycle of the new frame. Entry from IDLE never gets here,
              // so the first frame after enabling produces no pulse.
              index_d      = '0;
              frame_d      = frame_q + 6'd1;
              frame_done_d = 1'b1;
            end else begin
              index_d = index_q + IDX_W'(1);
            end
          end else begin
            dwell_d = dwell_q + DWELL_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          index_d = '0;
          dwell_d = '0;
          blank_d = '0;
        end
      endcase
    end
  end

  // Output decode works on the *next* state so the registered outputs line
  // up with the state they describe instead of lagging it by a cycle.
  always_comb begin
    an_onehot = '0;
    blink_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (index_d == IDX_W'(i)) begin
        an_onehot[i] = 1'b1;
        blink_sel    = blink_mask[i];
      end
    end
  end

  always_comb begin
    dark  = frame_d[5] & blink_sel;
    lit   = (dwell_d[DWELL_W-1 -: 3] <= bright);
    seg_d = '0;
    an_d  = '0;
    if (state_d == SHOW && !dark) begin
      an_d = an_onehot;
      if (lit) begin
        seg_d = shadow_d;
      end
    end
  end

  // Single state register; seg/an/frame_done come straight from flops so
  // there is no combinational path from any input to the display pins.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      index_q    <= '0;
      dwell_q    <= '0;
      blank_q    <= '0;
      frame_q    <= '0;
      shadow_q   <= '0;
      seg        <= '0;
      an         <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      dwell_q    <= dwell_d;
      blank_q    <= blank_d;
      frame_q    <= frame_d;
      shadow_q   <= shadow_d;
      seg        <= seg_d;
      an         <= an_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_zymason_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_zymason_scan_mux
//
// Scoreboard bench for zymason_scan_mux with default parameters. Inputs are
// driven on the falling edge; a reference model describes the display as a
// position within a frame (slot = BLANK + SHOW cycles) and pushes the expected
// outputs for the coming rising edge. A separate monitor pops and compares
// shortly after each rising edge.
// ---------------------------------------------------------------------------
module tb_zymason_scan_mux;

  localparam int ND       = 4;
  localparam int DW       = 8;
  localparam int BC       = 4;
  localparam int SHOW_LEN = 1 << DW;
  localparam int SLOT     = BC + SHOW_LEN;
  localparam int FRAME    = ND * SLOT;

  logic          clock;
  logic          reset;
  logic          en;
  logic [7*ND-1:0] digits;
  logic [2:0]    bright;
  logic [ND-1:0] blink_mask;
  logic [6:0]    seg;
  logic [ND-1:0] an;
  logic          frame_done;

  typedef struct packed {
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic          fd;
  } exp_t;

  exp_t sb[$];

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model state
  bit         m_run    = 1'b0;
  int         m_t      = 0;
  int         m_fbase  = 0;
  int         m_digit  = 0;
  int         m_off    = 0;
  logic [6:0] m_shadow = '0;
  exp_t       exp_cur;

  // current stimulus values
  logic          cur_r;
  logic          cur_e;
  logic [7*ND-1:0] cur_d;
  logic [2:0]    cur_b;
  logic [ND-1:0] cur_m;

  zymason_scan_mux #(
    .NUM_DIGITS(ND),
    .DWELL_W   (DW),
    .BLANK_CYC (BC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .digits    (digits),
    .bright    (bright),
    .blink_mask(blink_mask),
    .seg       (seg),
    .an        (an),
    .frame_done(frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int modelFrame();
    if (m_run) return (m_fbase + m_t / FRAME) % 64;
    return m_fbase;
  endfunction

  // Expected outputs after the coming rising edge, from the inputs now applied.
  task automatic modelStep();
    int pos;
    int dwell;
    int frame;
    bit blank_dark;
    exp_cur = '0;
    if (reset) begin
      m_run    = 1'b0;
      m_t      = 0;
      m_fbase  = 0;
      m_shadow = '0;
    end else if (!en) begin
      if (m_run) m_fbase = (m_fbase + m_t / FRAME) % 64;
      m_run = 1'b0;
      m_t   = 0;
    end else begin
      if (m_run) m_t = m_t + 1;
      else begin
        m_run = 1'b1;
        m_t   = 0;
      end
      pos     = m_t % FRAME;
      m_digit = pos / SLOT;
      m_off   = pos % SLOT;
      frame   = (m_fbase + m_t / FRAME) % 64;
      exp_cur.fd = (pos == 0 && m_t > 0);
      if (m_off >= BC) begin
        if (m_off == BC) m_shadow = digits[7*m_digit +: 7];
        dwell      = m_off - BC;
        blank_dark = (frame >= 32) && blink_mask[m_digit];
        if (!blank_dark) begin
          exp_cur.an = ND'(1 << m_digit);
          if (dwell / (SHOW_LEN / 8) <= int'(bright)) exp_cur.seg = m_shadow;
        end
      end
    end
  endtask

  task automatic applyStimulus();
    @(negedge clock);
    reset      = cur_r;
    en         = cur_e;
    digits     = cur_d;
    bright     = cur_b;
    blink_mask = cur_m;
    modelStep();
    sb.push_back(exp_cur);
  endtask

  task automatic checkOutput(input exp_t e);
    tests_run++;
    if (seg !== e.seg) begin
      tests_failed++;
      $display("[TB] FAIL seg at %0t: got %h expected %h", $time, seg, e.seg);
    end
    tests_run++;
    if (an !== e.an) begin
      tests_failed++;
      $display("[TB] FAIL an at %0t: got %b expected %b", $time, an, e.an);
    end
    tests_run++;
    if (frame_done !== e.fd) begin
      tests_failed++;
      $display("[TB] FAIL frame_done at %0t: got %b expected %b", $time, frame_done, e.fd);
    end
    tests_run++;
    if ($countones(an) > 1) begin
      tests_failed++;
      $display("[TB] FAIL an_onehot at %0t: got %b expected at most one bit", $time, an);
    end
  endtask

  // monitor: compares whatever the scoreboard expects for this edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic reachCheck(input string name, input bit reached);
    tests_run++;
    if (!reached) begin
      tests_failed++;
      $display("[TB] FAIL %s: got not reached expected reached", name);
    end
  endtask

  initial begin
    bit reached;
    int drop_left;
    reset      = 1'b1;
    en         = 1'b0;
    digits     = '0;
    bright     = '0;
    blink_mask = '0;
    cur_r = 1'b1;
    cur_e = 1'b1;
    cur_d = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    cur_b = 3'd7;
    cur_m = '0;

    $display("[TB] reset and first frames at full brightness");
    repeat (3) applyStimulus();
    cur_r = 1'b0;
    repeat (1100) applyStimulus();

    $display("[TB] dimming at bright=0 then bright=3");
    cur_b = 3'd0;
    repeat (FRAME) applyStimulus();
    cur_b = 3'd3;
    repeat (FRAME) applyStimulus();

    $display("[TB] digit 0 pattern change mid-SHOW");
    cur_b = 3'd7;
    reached = 1'b0;
    for (int i = 0; i < 3 * FRAME && !reached; i++) begin
      applyStimulus();
      if (m_run && m_digit == 0 && m_off >= BC + 40) reached = 1'b1;
    end
    reachCheck("reach_digit0_show", reached);
    cur_d[6:0] = 7'h7F;
    repeat (FRAME + 300) applyStimulus();

    $display("[TB] one-cycle enable drop mid-SHOW of digit 2");
    reached = 1'b0;
    for (int i = 0; i < 3 * FRAME && !reached; i++) begin
      applyStimulus();
      if (m_run && m_digit == 2 && m_off >= BC + 60) reached = 1'b1;
    end
    reachCheck("reach_digit2_show", reached);
    cur_e = 1'b0;
    applyStimulus();
    cur_e = 1'b1;
    repeat (FRAME + 20) applyStimulus();

    $display("[TB] randomized run through the blink half of the frame cycle");
    cur_m     = 4'b0010;
    drop_left = 0;
    for (int i = 0; i < 45000 && modelFrame() < 34; i++) begin
      if ($urandom_range(0, 63) == 0) cur_b = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) cur_d = 28'($urandom);
      if ($urandom_range(0, 499) == 0)
        cur_m = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0010;
      if (drop_left > 0) begin
        drop_left--;
        cur_e = (drop_left == 0);
      end else if ($urandom_range(0, 4999) == 0) begin
        drop_left = $urandom_range(1, 3);
        cur_e     = 1'b0;
      end
      applyStimulus();
    end
    cur_e = 1'b1;
    reachCheck("reach_blink_frames", modelFrame() >= 33);

    $display("[TB] reset asserted mid-SHOW");
    reached = 1'b0;
    for (int i = 0; i < 3 * FRAME && !reached; i++) begin
      applyStimulus();
      if (m_run && m_off >= BC + 5) reached = 1'b1;
    end
    reachCheck("reach_show_for_reset", reached);
    cur_r = 1'b1;
    applyStimulus();
    cur_r = 1'b0;
    cur_m = '0;
    repeat (600) applyStimulus();

    repeat (3) @(posedge clock);
    #2;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
